// File: rtl/mp_adder_seq.sv
// Multi-precision add/subtract sequencer: one W-bit chunk per cycle through a shared prefix carry chain.
// Optional signed-overflow output is enabled by defining MP_ADDER_SEQ_OVF_EN.

module carry_chain_hybrid #(
   parameter int W = 32
) (
   input  logic [W-1:0] g,
   input  logic [W-1:0] p,
   input  logic         cin,
   output logic [W:0]   c
);

   logic [W-1:0] gv;
   logic [W-1:0] pv;

   // In-place prefix tree; walking i downward keeps each level reading the previous level's values
   always_comb begin
      gv = g;
      pv = p;
      for (int d = 1; d < W; d = d * 2) begin
         for (int i = W - 1; i >= d; i--) begin
            gv[i] = gv[i] | (pv[i] & gv[i-d]);
            pv[i] = pv[i] & pv[i-d];
         end
      end
      c = {gv, cin};
   end

endmodule

module mp_adder_seq #(
   parameter int W = 32,
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_vld,
   output logic           in_rdy,
   input  logic [N*W-1:0] in_a,
   input  logic [N*W-1:0] in_b,
   input  logic           in_sub,
   output logic           out_vld,
   input  logic           out_rdy,
   output logic [N*W-1:0] out_sum,
   output logic           out_co,
   output logic           busy
`ifdef MP_ADDER_SEQ_OVF_EN
   ,
   output logic           out_ovf
`endif
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_next;

   logic [N*W-1:0] a_reg;
   logic [N*W-1:0] b_reg;
   logic [CW-1:0]  cnt;
   logic           carry;

   logic [W-1:0]   a_k, b_k, p_k, g_k, sum_k;
   logic [W:0]     c_k;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_rdy     = 1'b0;
      out_vld    = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            in_rdy = 1'b1;
            busy   = 1'b0;
            if (in_vld) state_next = RUN;
         end
         RUN: begin
            if (cnt == LAST) state_next = DONE;
         end
         DONE: begin
            out_vld = 1'b1;
            if (out_rdy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Carry-in is folded into bit 0's generate so the chain needs no separate carry input path
   always_comb begin
      a_k    = a_reg[cnt*W +: W];
      b_k    = b_reg[cnt*W +: W];
      p_k    = a_k ^ b_k;
      g_k    = a_k & b_k;
      g_k[0] = g_k[0] | (p_k[0] & carry);
      sum_k  = p_k ^ c_k[W-1:0];
   end

   carry_chain_hybrid #(.W(W)) u_chain (
      .g   (g_k),
      .p   (p_k),
      .cin (carry),
      .c   (c_k)
   );

   // Subtraction stores ~B with carry-in 1, so the chain only ever adds
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         out_sum <= '0;
         out_co  <= 1'b0;
`ifdef MP_ADDER_SEQ_OVF_EN
         out_ovf <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_vld) begin
                  a_reg <= in_a;
                  b_reg <= in_sub ? ~in_b : in_b;
                  carry <= in_sub;
                  cnt   <= '0;
               end
            end
            RUN: begin
               out_sum[cnt*W +: W] <= sum_k;
               carry               <= c_k[W];
               if (cnt == LAST) begin
                  out_co <= c_k[W];
`ifdef MP_ADDER_SEQ_OVF_EN
                  out_ovf <= c_k[W] ^ c_k[W-1];
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mp_adder_seq.sv
// Directed self-checking bench for mp_adder_seq (W=32, N=4).
// Overflow checks run only when MP_ADDER_SEQ_OVF_EN is defined.

module tb_mp_adder_seq;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int NW = N * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_vld;
   logic          in_rdy;
   logic [NW-1:0] in_a;
   logic [NW-1:0] in_b;
   logic          in_sub;
   logic          out_vld;
   logic          out_rdy;
   logic [NW-1:0] out_sum;
   logic          out_co;
   logic          busy;
`ifdef MP_ADDER_SEQ_OVF_EN
   logic          out_ovf;
`endif

   int checks = 0;
   int errors = 0;

   mp_adder_seq #(.W(W), .N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .in_a    (in_a),
      .in_b    (in_b),
      .in_sub  (in_sub),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .out_sum (out_sum),
      .out_co  (out_co),
      .busy    (busy)
`ifdef MP_ADDER_SEQ_OVF_EN
      ,
      .out_ovf (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   // Issues one operation and waits (bounded) for out_vld; lat counts cycles after the accepting edge
   task automatic run_op(input logic [NW-1:0] a, input logic [NW-1:0] b, input logic sub,
                         output int lat);
      int guard;
      in_a   = a;
      in_b   = b;
      in_sub = sub;
      in_vld = 1'b1;
      guard  = 0;
      while (!in_rdy && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      in_vld = 1'b0;
      lat    = 0;
      while (!out_vld && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_rdy: got %b expected 1", in_rdy); end
      checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_vld: got %b expected 0", out_vld); end
      checks++; if (out_sum !== '0) begin errors++; $display("[TB] FAIL reset_out_sum: got %h expected 0", out_sum); end
      checks++; if (out_co !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_co: got %b expected 0", out_co); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_add_wrap;
      int lat;
      out_rdy = 1'b1;
      run_op({NW{1'b1}}, 128'd1, 1'b0, lat);
      checks++; if (lat !== N) begin errors++; $display("[TB] FAIL add_wrap_latency: got %0d expected %0d", lat, N); end
      checks++; if (out_sum !== 128'd0) begin errors++; $display("[TB] FAIL add_wrap_sum: got %h expected 0", out_sum); end
      checks++; if (out_co !== 1'b1) begin errors++; $display("[TB] FAIL add_wrap_co: got %b expected 1", out_co); end
      @(posedge clk); #1;
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL add_wrap_idle: in_rdy got %b expected 1", in_rdy); end
   endtask

   task automatic test_sub;
      int lat;
      out_rdy = 1'b1;
      run_op(128'd0, 128'd1, 1'b1, lat);
      checks++; if (out_sum !== {NW{1'b1}}) begin errors++; $display("[TB] FAIL sub_borrow_sum: got %h expected all ones", out_sum); end
      checks++; if (out_co !== 1'b0) begin errors++; $display("[TB] FAIL sub_borrow_co: got %b expected 0", out_co); end
      @(posedge clk); #1;
      run_op(128'd5, 128'd5, 1'b1, lat);
      checks++; if (out_sum !== 128'd0) begin errors++; $display("[TB] FAIL sub_equal_sum: got %h expected 0", out_sum); end
      checks++; if (out_co !== 1'b1) begin errors++; $display("[TB] FAIL sub_equal_co: got %b expected 1", out_co); end
      @(posedge clk); #1;
   endtask

   task automatic test_chunk_carry;
      int lat;
      out_rdy = 1'b1;
      run_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, lat);
      checks++; if (out_sum !== 128'h00000001_00000000_00000000_00000000) begin errors++; $display("[TB] FAIL chunk_carry_sum: got %h expected 00000001_00000000_00000000_00000000", out_sum); end
      checks++; if (out_co !== 1'b0) begin errors++; $display("[TB] FAIL chunk_carry_co: got %b expected 0", out_co); end
      @(posedge clk); #1;
      run_op(128'h12345678_9ABCDEF0_0F0F0F0F_80000000, 128'h11111111_11111111_F0F0F0F1_80000000, 1'b0, lat);
      checks++; if (out_sum !== 128'h23456789_ABCDF002_00000001_00000000) begin errors++; $display("[TB] FAIL mixed_add_sum: got %h expected 23456789_abcdf002_00000001_00000000", out_sum); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      int lat;
      out_rdy = 1'b0;
      run_op(128'd1, 128'd2, 1'b0, lat);
      for (int i = 0; i < 5; i++) begin
         in_vld = 1'b1;
         in_a   = 128'(i + 100);
         @(posedge clk); #1;
         checks++; if (out_vld !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_vld[%0d]: got %b expected 1", i, out_vld); end
         checks++; if (out_sum !== 128'd3) begin errors++; $display("[TB] FAIL bp_out_sum[%0d]: got %h expected 3", i, out_sum); end
         checks++; if (in_rdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_rdy[%0d]: got %b expected 0", i, in_rdy); end
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_in_rdy: got %b expected 1", in_rdy); end
      checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_out_vld: got %b expected 0", out_vld); end
      checks++; if (out_sum !== 128'd3) begin errors++; $display("[TB] FAIL bp_idle_hold_sum: got %h expected 3", out_sum); end
   endtask

   task automatic test_reset_mid_run;
      int lat;
      out_rdy = 1'b1;
      in_a    = 128'd5;
      in_b    = 128'd6;
      in_sub  = 1'b0;
      in_vld  = 1'b1;
      @(posedge clk); #1;
      in_vld = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_pre_busy: got %b expected 1", busy); end
      rst = 1'b1;
      #1;
      checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL abort_out_vld: got %b expected 0", out_vld); end
      checks++; if (out_sum !== 128'd0) begin errors++; $display("[TB] FAIL abort_out_sum: got %h expected 0", out_sum); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_rdy !== 1'b1) begin errors++; $display("[TB] FAIL abort_in_rdy: got %b expected 1", in_rdy); end
      checks++; if (out_vld !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_result: got %b expected 0", out_vld); end
      run_op(128'd3, 128'd4, 1'b0, lat);
      checks++; if (out_sum !== 128'd7) begin errors++; $display("[TB] FAIL after_abort_sum: got %h expected 7", out_sum); end
      checks++; if (out_co !== 1'b0) begin errors++; $display("[TB] FAIL after_abort_co: got %b expected 0", out_co); end
      @(posedge clk); #1;
   endtask

`ifdef MP_ADDER_SEQ_OVF_EN
   task automatic test_overflow;
      int lat;
      out_rdy = 1'b1;
      run_op({1'b0, {(NW-1){1'b1}}}, 128'd1, 1'b0, lat);
      checks++; if (out_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_pos_ovf: got %b expected 1", out_ovf); end
      checks++; if (out_co !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pos_co: got %b expected 0", out_co); end
      @(posedge clk); #1;
      run_op({1'b1, {(NW-1){1'b0}}}, {1'b1, {(NW-1){1'b0}}}, 1'b0, lat);
      checks++; if (out_ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_neg_ovf: got %b expected 1", out_ovf); end
      checks++; if (out_co !== 1'b1) begin errors++; $display("[TB] FAIL ovf_neg_co: got %b expected 1", out_co); end
      checks++; if (out_sum !== 128'd0) begin errors++; $display("[TB] FAIL ovf_neg_sum: got %h expected 0", out_sum); end
      @(posedge clk); #1;
      run_op(128'd1, 128'd1, 1'b0, lat);
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_none: got %b expected 0", out_ovf); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      rst     = 1'b1;
      in_vld  = 1'b0;
      in_a    = '0;
      in_b    = '0;
      in_sub  = 1'b0;
      out_rdy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_add_wrap();
      test_sub();
      test_chunk_carry();
      test_backpressure();
      test_reset_mid_run();
`ifdef MP_ADDER_SEQ_OVF_EN
      test_overflow();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
